// File: rtl/loc_ram_pkg.sv
// ============================================================================
// Module  : loc_ram_pkg
// Brief   : Shared constants and sizing helpers for the RAM write buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package loc_ram_pkg;

    localparam int c_WBUF_DEPTH_DEF = 4;

    // Pointer width for a modulo-depth pointer; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a buffered {addr, data} entry.
    function automatic int entry_w(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/loc_wbuf_fifo.sv
// ============================================================================
// Module  : loc_wbuf_fifo
// Brief   : In-order entry storage with modulo pointers, occupancy count and
//           an in-place overwrite port for the newest entry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module loc_wbuf_fifo
    import loc_ram_pkg::*;
#(
    parameter int DEPTH = c_WBUF_DEPTH_DEF,
    parameter int EW    = 64,
    parameter int PW    = ptr_w(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_ovr,
    input  logic [EW-1:0] i_din,
    output logic [EW-1:0] o_head,
    output logic [EW-1:0] o_tail,
    output logic [CW-1:0] o_cnt,
    output logic          o_full
);

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_full;

    logic [PW-1:0] w_tail_idx;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // Explicit wrap so non-power-of-2 depths stay correct.
    assign w_wptr_nxt = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
    assign w_tail_idx = (r_wptr == '0) ? PW'(DEPTH - 1) : r_wptr - 1'b1;
    assign w_cnt_nxt  = r_cnt + CW'(i_push) - CW'(i_pop);

    assign o_head = r_mem[r_rptr];
    assign o_tail = r_mem[w_tail_idx];
    assign o_cnt  = r_cnt;
    assign o_full = r_full;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end else if (i_ovr) begin
            r_mem[w_tail_idx] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (i_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CW'(DEPTH));
        end
    end

endmodule

`default_nettype wire

// File: rtl/loc_ram_wbuf.sv
// ============================================================================
// Module  : loc_ram_wbuf
// Brief   : Write buffer between address conversion and RAM, with same-address
//           coalescing, drop-on-full and a sticky overflow flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module loc_ram_wbuf
    import loc_ram_pkg::*;
#(
    parameter int LOC_AWIDTH = 32,
    parameter int LOC_DWIDTH = 32,
    parameter int WBUF_DEPTH = c_WBUF_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            loc_data_in_en,
    input  logic [LOC_AWIDTH-1:0]           loc_data_in_addr,
    input  logic [LOC_DWIDTH-1:0]           loc_data_in,
    output logic                            ram_wr_en,
    input  logic                            ram_wr_rdy,
    output logic [LOC_AWIDTH-1:0]           ram_wr_addr,
    output logic [LOC_DWIDTH-1:0]           ram_wr_data,
    output logic [$clog2(WBUF_DEPTH+1)-1:0] wbuf_cnt,
    output logic                            wbuf_full,
    output logic                            ovf_err,
    input  logic                            ovf_clr
);

    localparam int c_EW = entry_w(LOC_AWIDTH, LOC_DWIDTH);
    localparam int c_CW = $clog2(WBUF_DEPTH + 1);

    logic [c_EW-1:0]       w_head;
    logic [c_EW-1:0]       w_tail;
    logic [LOC_AWIDTH-1:0] w_tail_addr;
    logic                  w_pop;
    logic                  w_coal;
    logic                  w_drop;
    logic                  w_push;
    logic                  r_ovf;

    assign w_tail_addr = w_tail[c_EW-1 -: LOC_AWIDTH];
    assign w_pop       = ram_wr_en & ram_wr_rdy;

    // With a single entry the newest is also the head; if it leaves this
    // cycle the write must become a fresh push instead of an overwrite.
    assign w_coal = loc_data_in_en && (wbuf_cnt != '0) &&
                    (w_tail_addr == loc_data_in_addr) &&
                    !((wbuf_cnt == c_CW'(1)) && w_pop);
    assign w_drop = loc_data_in_en && wbuf_full && !w_pop && !w_coal;
    assign w_push = loc_data_in_en && !w_coal && !w_drop;

    loc_wbuf_fifo #(
        .DEPTH (WBUF_DEPTH),
        .EW    (c_EW)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_ovr  (w_coal),
        .i_din  ({loc_data_in_addr, loc_data_in}),
        .o_head (w_head),
        .o_tail (w_tail),
        .o_cnt  (wbuf_cnt),
        .o_full (wbuf_full)
    );

    assign ram_wr_en   = (wbuf_cnt != '0);
    assign ram_wr_addr = w_head[c_EW-1 -: LOC_AWIDTH];
    assign ram_wr_data = w_head[LOC_DWIDTH-1:0];
    assign ovf_err     = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_loc_ram_wbuf.sv
// ============================================================================
// Module  : tb_loc_ram_wbuf
// Brief   : Directed self-checking bench for loc_ram_wbuf.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loc_ram_wbuf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        loc_data_in_en = 1'b0;
    logic [31:0] loc_data_in_addr = '0;
    logic [31:0] loc_data_in = '0;
    logic        ram_wr_en;
    logic        ram_wr_rdy = 1'b0;
    logic [31:0] ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic [2:0]  wbuf_cnt;
    logic        wbuf_full;
    logic        ovf_err;
    logic        ovf_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    loc_ram_wbuf #(
        .LOC_AWIDTH (32),
        .LOC_DWIDTH (32),
        .WBUF_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .loc_data_in_en   (loc_data_in_en),
        .loc_data_in_addr (loc_data_in_addr),
        .loc_data_in      (loc_data_in),
        .ram_wr_en        (ram_wr_en),
        .ram_wr_rdy       (ram_wr_rdy),
        .ram_wr_addr      (ram_wr_addr),
        .ram_wr_data      (ram_wr_data),
        .wbuf_cnt         (wbuf_cnt),
        .wbuf_full        (wbuf_full),
        .ovf_err          (ovf_err),
        .ovf_clr          (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        loc_data_in_en   = 1'b1;
        loc_data_in_addr = a;
        loc_data_in      = d;
        step();
        loc_data_in_en   = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_en"},   64'(ram_wr_en),   64'd1);
        chk({tag, "_addr"}, 64'(ram_wr_addr), 64'(a));
        chk({tag, "_data"}, 64'(ram_wr_data), 64'(d));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_en",   64'(ram_wr_en), 64'd0);
        chk("rst_cnt",  64'(wbuf_cnt),  64'd0);
        chk("rst_full", 64'(wbuf_full), 64'd0);
        chk("rst_ovf",  64'(ovf_err),   64'd0);
        rst_n = 1'b1;
        step();

        // Single write
        ram_wr_rdy = 1'b1;
        wr(32'h10, 32'hA5A5A5A5);
        chk("single_cnt", 64'(wbuf_cnt), 64'd1);
        expect_head("single", 32'h10, 32'hA5A5A5A5);
        step();
        chk("single_cnt0", 64'(wbuf_cnt), 64'd0);
        chk("single_en0",  64'(ram_wr_en), 64'd0);

        // Stall, fill, drop, ordered drain
        ram_wr_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("stall_full_pre%0d", i), 64'(wbuf_full), 64'd0);
            wr(32'(i), 32'h100 + 32'(i));
        end
        chk("stall_cnt",  64'(wbuf_cnt),  64'd4);
        chk("stall_full", 64'(wbuf_full), 64'd1);
        chk("stall_ovf0", 64'(ovf_err),   64'd0);
        wr(32'h5, 32'h105);
        chk("drop_cnt", 64'(wbuf_cnt), 64'd4);
        chk("drop_ovf", 64'(ovf_err),  64'd1);
        expect_head("drop_head", 32'h1, 32'h101);
        ram_wr_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            expect_head($sformatf("drain%0d", i), 32'(i), 32'h100 + 32'(i));
            step();
        end
        chk("drain_cnt",  64'(wbuf_cnt),  64'd0);
        chk("drain_en",   64'(ram_wr_en), 64'd0);
        chk("drain_full", 64'(wbuf_full), 64'd0);
        chk("drain_ovf",  64'(ovf_err),   64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_ovf", 64'(ovf_err), 64'd0);

        // Coalesce on newest entry
        ram_wr_rdy = 1'b0;
        wr(32'h20, 32'h11);
        wr(32'h20, 32'h22);
        chk("coal_cnt", 64'(wbuf_cnt), 64'd1);
        expect_head("coal", 32'h20, 32'h22);
        ram_wr_rdy = 1'b1;
        step();
        chk("coal_cnt0", 64'(wbuf_cnt), 64'd0);
        chk("coal_en0",  64'(ram_wr_en), 64'd0);

        // Same address as a head leaving this cycle: fresh push, not overwrite
        ram_wr_rdy = 1'b0;
        wr(32'h80, 32'h1);
        ram_wr_rdy = 1'b1;
        expect_head("hpop_old", 32'h80, 32'h1);
        wr(32'h80, 32'h2);
        chk("hpop_cnt", 64'(wbuf_cnt), 64'd1);
        expect_head("hpop_new", 32'h80, 32'h2);
        step();
        chk("hpop_cnt0", 64'(wbuf_cnt), 64'd0);

        // Full with simultaneous pop; drain crosses the pointer wrap
        ram_wr_rdy = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h40 + 32'(i), 32'h400 + 32'(i));
        chk("fp_full", 64'(wbuf_full), 64'd1);
        ram_wr_rdy = 1'b1;
        wr(32'h30, 32'h3030);
        chk("fp_cnt",  64'(wbuf_cnt), 64'd4);
        chk("fp_ovf",  64'(ovf_err),  64'd0);
        for (int i = 1; i < 4; i++) begin
            expect_head($sformatf("fp_drain%0d", i), 32'h40 + 32'(i), 32'h400 + 32'(i));
            step();
        end
        expect_head("fp_drain_new", 32'h30, 32'h3030);
        step();
        chk("fp_cnt0", 64'(wbuf_cnt), 64'd0);

        // Reset mid-drain
        ram_wr_rdy = 1'b0;
        for (int i = 0; i < 3; i++) wr(32'h50 + 32'(i), 32'h500 + 32'(i));
        chk("rm_cnt3", 64'(wbuf_cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("rm_en",  64'(ram_wr_en), 64'd0);
        chk("rm_cnt", 64'(wbuf_cnt),  64'd0);
        loc_data_in_en   = 1'b1;
        loc_data_in_addr = 32'h60;
        loc_data_in      = 32'h600;
        step();
        chk("rm_ign", 64'(wbuf_cnt), 64'd0);
        loc_data_in_en = 1'b0;
        rst_n      = 1'b1;
        ram_wr_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rm_stale%0d", i), 64'(ram_wr_en), 64'd0);
        end

        // ovf_clr racing a drop, then ovf_clr alone
        ram_wr_rdy = 1'b0;
        for (int i = 0; i < 4; i++) wr(32'h70 + 32'(i), 32'h700 + 32'(i));
        wr(32'h74, 32'h704);
        chk("oc_ovf1", 64'(ovf_err), 64'd1);
        ovf_clr = 1'b1;
        wr(32'h75, 32'h705);
        chk("oc_race", 64'(ovf_err),  64'd1);
        chk("oc_cnt",  64'(wbuf_cnt), 64'd4);
        step();
        ovf_clr = 1'b0;
        chk("oc_clr", 64'(ovf_err), 64'd0);
        expect_head("oc_head", 32'h70, 32'h700);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
